// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, shift/rotate/serial-fill steps, and a
// start/count sequencer that runs a counted burst of steps and pulses done when finished.
module univ_shift_reg #(
    parameter int WIDTH    = 8,
    parameter int AMT_W    = 3,
    parameter int CNT_W    = 8,
    parameter bit FREE_RUN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             sin,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] po,
    output logic             so,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [2:0]       lat_mode;
    logic [AMT_W-1:0] lat_amt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       eff_mode;

    // One shift step; rotates go through a doubled word so any amount mod WIDTH works.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [WIDTH-1:0] v,
        input logic [2:0]       m,
        input logic [AMT_W-1:0] a,
        input logic             s
    );
        logic [2*WIDTH-1:0] dbl;
        int unsigned        r;
        r   = 32'(a) % 32'(WIDTH);
        dbl = {v, v};
        step_fn = v;
        case (m)
            3'b001: step_fn = v << a;
            3'b010: step_fn = v >> a;
            3'b011: begin
                dbl     = dbl << r;
                step_fn = dbl[2*WIDTH-1:WIDTH];
            end
            3'b100: begin
                dbl     = dbl >> r;
                step_fn = dbl[WIDTH-1:0];
            end
            3'b101: step_fn = $unsigned($signed(v) >>> a);
            3'b110: step_fn = {v[WIDTH-2:0], s};
            3'b111: step_fn = {s, v[WIDTH-1:1]};
            default: step_fn = v;
        endcase
    endfunction

    assign eff_mode = (state == RUN) ? lat_mode : mode;
    assign so = (eff_mode == 3'b001 || eff_mode == 3'b011 || eff_mode == 3'b110)
                ? po[WIDTH-1] : po[0];

    // Handshake: start is taken only in IDLE (i.e. while busy=0 or during the done
    // cycle); busy stays high for exactly the burst; done pulses once at the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            po       <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            lat_mode <= 3'b000;
            lat_amt  <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                po    <= load_value;
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (count != '0) begin
                                lat_mode <= mode;
                                lat_amt  <= amount;
                                cnt      <= count;
                                state    <= RUN;
                                busy     <= 1'b1;
                            end else begin
                                done <= 1'b1;
                            end
                        end else if (FREE_RUN) begin
                            po <= step_fn(po, mode, amount, sin);
                        end
                    end
                    RUN: begin
                        po  <= step_fn(po, lat_mode, lat_amt, sin);
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register and the next-generation replacement for the fixed-direction, fixed-amount shift register. Width, shift mode and shift amount are configurable, and a start/count sequencer performs a counted burst of shift steps and reports completion. It sits in the datapath wherever a word must be loaded, transformed by a programmed number of shift/rotate steps, or serialised/deserialised one bit per clock.

## Interface
- WIDTH, 8: register width in bits (≥2).
- AMT_W, 3: width of `amount`; 2**AMT_W ≥ WIDTH required.
- CNT_W, 8: width of `count`.
- FREE_RUN, 0: when 1, the register applies live `mode`/`amount` every idle cycle, reproducing legacy continuous-shift behaviour.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- load  input  1  parallel load strobe.
- load_value  input  WIDTH  parallel load data.
- mode  input  3  operation select: 000 hold, 001 logical left, 010 logical right, 011 rotate left, 100 rotate right, 101 arithmetic right, 110 serial-fill left, 111 serial-fill right.
- amount  input  AMT_W  shift distance per step (modes 001–101).
- sin  input  1  serial data in (modes 110/111).
- start  input  1  begin a counted burst.
- count  input  CNT_W  number of steps in the burst.
- po  output  WIDTH  register contents.
- so  output  1  serial out: `po[WIDTH-1]` when the effective mode is 001/011/110, else `po[0]`.
- busy  output  1  burst in progress.
- done  output  1  one-cycle burst-completion pulse.

## Operation
- Priority per edge: rst > load > start (IDLE only) > step.
- Reset: po=0, busy=0, done=0, state IDLE, step counter 0.
- load: po←load_value; a running burst is aborted (state→IDLE, busy=0), no done pulse.
- FSM states: IDLE, RUN.
- IDLE, start=1, count>0: latch mode, amount and count; state→RUN; busy=1; po unchanged this edge.
- IDLE, start=1, count=0: done=1 for one cycle; po unchanged; stays IDLE.
- RUN: one step per edge using the latched mode/amount, counter decrements. On the step that brings the counter to 0, state→IDLE, busy=0 and done=1, all on the same edge.
- start while RUN: ignored. Changes to mode/amount while RUN have no effect.
- IDLE without start: po holds (FREE_RUN=0), or one step with live mode/amount (FREE_RUN=1).
- Step arithmetic:
  - amount=0: no change.
  - Logical shifts zero-fill; amount ≥ WIDTH gives 0.
  - Rotates use amount mod WIDTH.
  - Arithmetic right replicates po[WIDTH-1]; amount ≥ WIDTH gives all sign bits.
- Serial-fill modes ignore amount and shift by exactly 1:
  - 110: po←{po[WIDTH-2:0], sin}.
  - 111: po←{sin, po[WIDTH-1:1]}.
  - sin is sampled at each step edge.
- mode 000 in RUN: counter runs, po holds, done is still produced.
- done is never asserted for two consecutive cycles except for back-to-back count=0 starts.

## Timing
- start sampled at edge E0. Steps occur at E1…EN. po after step k is visible after Ek.
- busy is high from after E0 until EN. done is high for the cycle after EN, coincident with the final po.
- Burst latency: N+1 edges from start to done. A new start is accepted on the cycle done is high.
- Load: po=load_value the cycle after the load edge.
- so is combinational from po and the effective mode: latched mode in RUN, live mode otherwise.

## Test plan
- Reset: rst=1 for 3 cycles with load=1, start=1 → po=8'h00, busy=0, done=0 throughout; first edge after release still obeys load.
- Left burst: load 8'h09, mode=001, amount=1, start with count=3 → po 8'h12, 8'h24, 8'h48 on successive edges; busy high for 3 cycles; done high exactly one cycle with po=8'h48.
- Rotate/arithmetic: load 8'h81, mode=100, amount=3, count=1 → po=8'h30. Load 8'h90, mode=101, amount=2, count=1 → po=8'hE4.
- Serial fill: load 8'h00, mode=110, count=4, sin=1,0,1,1 on the step edges → po=8'h0B, so=0 after completion, done one cycle.
- Abort and edge cases:
  - start count=5, mode=001, amount=1 from 8'h01; assert load with 8'hA5 before step 3 → po=8'hA5, busy=0, no done.
  - start during busy is ignored (burst length unchanged).
  - count=0 → done next cycle, po unchanged.
- FREE_RUN=1: load 8'h09, load=0, mode=001, amount=1 → po doubles every cycle (8'h12, 8'h24 …) with busy=0; 1000 random load/load_value cycles checked against a reference model.
